// File: rtl/fft_ram_streamer_pkg.sv
// Shared FFT constants, stream-state encoding and the address bit-reverse helper.
package fft_consts;

    localparam int N          = 8;
    localparam int LOG2N      = $clog2(N);
    localparam int DW_COMPLEX = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_UNLOAD
    } fft_stream_state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO absorbing RAM read latency ahead of the output stream.
module stream_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wptr_q, rptr_q;
    logic [1:0]   count_q;
    logic         push_ok, pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop_ok) rptr_q <= ~rptr_q;
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign dout_o  = valid_o ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fft_ram_streamer.sv
// Streams one N-sample frame into a dual-port RAM (optionally bit-reversed) and
// back out in natural order through a 2-entry FIFO with backpressure.
module fft_ram_streamer
    import fft_consts::*;
#(
    parameter bit BITREV_LOAD = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  unload_start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW_COMPLEX-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DW_COMPLEX-1:0] m_data,
    output logic                  m_last,
    output logic                  ena,
    output logic                  wea,
    output logic [LOG2N-1:0]      addra,
    output logic [DW_COMPLEX-1:0] dina,
    output logic                  enb,
    output logic                  web,
    output logic [LOG2N-1:0]      addrb,
    input  logic [DW_COMPLEX-1:0] doutb,
    output logic                  load_done,
    output logic                  unload_done,
    output logic                  busy
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    fft_stream_state_t state_q, state_d;
    logic [LOG2N-1:0]  wcnt_q, wcnt_d;
    logic [LOG2N-1:0]  rcnt_q, rcnt_d;
    logic [LOG2N-1:0]  ocnt_q, ocnt_d;
    logic              issued_all_q, issued_all_d;
    logic              inflight_q;
    logic              load_done_q, load_done_d;
    logic              unload_done_q, unload_done_d;

    logic [1:0]        fifo_count;
    logic              pop;
    logic [2:0]        occ;
    logic              room;

    assign pop  = m_valid && m_ready;
    assign occ  = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign room = (occ < 3'd2);

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        ocnt_d        = ocnt_q;
        issued_all_d  = issued_all_q;
        load_done_d   = 1'b0;
        unload_done_d = 1'b0;
        s_ready       = 1'b0;
        ena           = 1'b0;
        wea           = 1'b0;
        addra         = '0;
        dina          = '0;
        enb           = 1'b0;
        addrb         = '0;
        m_last        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    ena    = 1'b1;
                    wea    = 1'b1;
                    dina   = s_data;
                    addra  = BITREV_LOAD ? bitrev(wcnt_q) : wcnt_q;
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_IDX) begin
                        state_d     = ST_HOLD;
                        load_done_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // Read 0 goes out in the start cycle itself, so rcnt enters UNLOAD
                // already pointing at sample 1; this buys the 2-cycle first-beat latency.
                if (unload_start) begin
                    state_d      = ST_UNLOAD;
                    enb          = 1'b1;
                    addrb        = '0;
                    rcnt_d       = LOG2N'(1);
                    ocnt_d       = '0;
                    issued_all_d = 1'b0;
                end
            end
            ST_UNLOAD: begin
                m_last = m_valid && (ocnt_q == LAST_IDX);
                if (!issued_all_q && room) begin
                    enb    = 1'b1;
                    addrb  = rcnt_q;
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == LAST_IDX) issued_all_d = 1'b1;
                end
                if (pop) begin
                    ocnt_d = ocnt_q + 1'b1;
                    if (m_last) begin
                        state_d       = ST_IDLE;
                        unload_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            ocnt_q        <= '0;
            issued_all_q  <= 1'b0;
            inflight_q    <= 1'b0;
            load_done_q   <= 1'b0;
            unload_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            ocnt_q        <= ocnt_d;
            issued_all_q  <= issued_all_d;
            inflight_q    <= enb;
            load_done_q   <= load_done_d;
            unload_done_q <= unload_done_d;
        end
    end

    stream_skid_fifo #(
        .W(DW_COMPLEX)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (inflight_q),
        .din_i  (doutb),
        .pop_i  (pop),
        .dout_o (m_data),
        .valid_o(m_valid),
        .count_o(fifo_count)
    );

    assign web         = 1'b0;
    assign load_done   = load_done_q;
    assign unload_done = unload_done_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_ram_streamer.sv
// Self-checking bench: two streamers (bit-reversed and natural load) share stimulus,
// each backed by a behavioural dual-port RAM, checked against a frame-level model.
module tb_fft_ram_streamer;
    import fft_consts::*;

    localparam int DW = DW_COMPLEX;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, load_start, unload_start, s_valid, m_ready, preload;
    logic [DW-1:0] s_data;

    logic             s_ready_a, m_valid_a, m_last_a, ena_a, wea_a, enb_a, web_a;
    logic             load_done_a, unload_done_a, busy_a;
    logic [DW-1:0]    m_data_a, dina_a, doutb_a;
    logic [LOG2N-1:0] addra_a, addrb_a;
    logic             s_ready_b, m_valid_b, m_last_b, ena_b, wea_b, enb_b, web_b;
    logic             load_done_b, unload_done_b, busy_b;
    logic [DW-1:0]    m_data_b, dina_b, doutb_b;
    logic [LOG2N-1:0] addra_b, addrb_b;

    fft_ram_streamer #(.BITREV_LOAD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .unload_start(unload_start),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a),
        .ena(ena_a), .wea(wea_a), .addra(addra_a), .dina(dina_a),
        .enb(enb_a), .web(web_a), .addrb(addrb_a), .doutb(doutb_a),
        .load_done(load_done_a), .unload_done(unload_done_a), .busy(busy_a));

    fft_ram_streamer #(.BITREV_LOAD(1'b0)) dut_nat (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .unload_start(unload_start),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b),
        .ena(ena_b), .wea(wea_b), .addra(addra_b), .dina(dina_b),
        .enb(enb_b), .web(web_b), .addrb(addrb_b), .doutb(doutb_b),
        .load_done(load_done_b), .unload_done(unload_done_b), .busy(busy_b));

    // Behavioural RAMs: synchronous write on A, one-cycle read on B, never reset.
    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] <= DW'(i);
                mem_b[i] <= DW'(i);
            end
        end else begin
            if (ena_a && wea_a) mem_a[addra_a] <= dina_a;
            if (ena_b && wea_b) mem_b[addra_b] <= dina_b;
        end
        if (enb_a) doutb_a <= mem_a[addrb_a];
        if (enb_b) doutb_b <= mem_b[addrb_b];
    end

    // Event monitor, sampled mid-cycle on the falling edge.
    int cyc = 0;
    logic [31:0] wra[$], wda[$], wca[$], wrb[$], wdb[$];
    logic [31:0] bda[$], bla[$], bca[$], bdb[$], blb[$];
    int ld_cnt = 0, ld_cyc = 0, ud_cnt = 0, ud_cyc = 0, us_cyc = 0, rd_cnt = 0;
    int stab_err = 0, ovf_err = 0, porta_err = 0, outst = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        cyc++;
        if (ena_a && wea_a) begin wra.push_back(32'(addra_a)); wda.push_back(dina_a); wca.push_back(cyc); end
        if (ena_b && wea_b) begin wrb.push_back(32'(addra_b)); wdb.push_back(dina_b); end
        if ((ena_a && !wea_a) || (ena_b && !wea_b) || web_a || web_b) porta_err++;
        if (load_done_a) begin ld_cnt++; ld_cyc = cyc; end
        if (unload_done_a) begin ud_cnt++; ud_cyc = cyc; end
        if (unload_start) us_cyc = cyc;
        if (m_valid_a && m_ready) begin
            bda.push_back(m_data_a); bla.push_back(32'(m_last_a)); bca.push_back(cyc);
        end
        if (m_valid_b && m_ready) begin bdb.push_back(m_data_b); blb.push_back(32'(m_last_b)); end
        if (!rst_n) begin
            outst = 0;
            prev_stall = 1'b0;
        end else begin
            if (enb_a) rd_cnt++;
            if (enb_a && (outst - int'(m_valid_a && m_ready)) >= 2) ovf_err++;
            outst = outst + int'(enb_a) - int'(m_valid_a && m_ready);
            if (prev_stall && (!m_valid_a || m_data_a !== prev_data)) stab_err++;
            prev_stall = m_valid_a && !m_ready;
            prev_data  = m_data_a;
        end
    end

    int checks = 0, errors = 0;
    logic [DW-1:0] d [N];
    logic [DW-1:0] ref_a [N];
    logic [DW-1:0] ref_b [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < LOG2N; b++)
            if (((k >> b) & 1) != 0) r += 1 << (LOG2N - 1 - b);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: s_valid always high, 1: alternating, 2: random. poke pulses unload_start mid-load.
    task automatic do_load(input int mode, input bit poke);
        int k = 0, t = 0, bw, bl;
        bw = wra.size();
        bl = ld_cnt;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        while (k < N && t < 200) begin
            s_valid      = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 0) : 1'($urandom_range(0, 1));
            s_data       = d[k];
            unload_start = poke && (t == 3);
            @(negedge clk);
            if (s_valid && s_ready_a) k++;
            tick();
            t++;
        end
        s_valid = 1'b0;
        unload_start = 1'b0;
        check("load_beats", 64'(k), 64'(N));
        check("load_done_first_hold", {load_done_a, busy_a, s_ready_a}, 3'b110);
        for (int i = 0; i < N; i++) begin
            ref_a[rev(i)] = d[i];
            ref_b[i]      = d[i];
        end
        tick();
        tick();
        check("wr_count", 64'(wra.size() - bw), 64'(N));
        for (int i = 0; i < N; i++) begin
            check("wr_bitrev", {wra[bw+i], wda[bw+i]}, {32'(rev(i)), d[i]});
            check("wr_natural", {wrb[bw+i], wdb[bw+i]}, {32'(i), d[i]});
        end
        check("load_done_once", 64'(ld_cnt - bl), 64'd1);
        check("load_done_timing", 64'(ld_cyc), 64'(wca[bw+N-1] + 1));
    endtask

    // mode 0: m_ready high, 1: pattern 1,0,0,1, 2: random. cut asserts reset after 5 beats.
    task automatic do_unload(input int mode, input bit cut);
        int t = 0, bb, bu, br, lim;
        logic [3:0] pat;
        pat = 4'b1001;
        bb = bda.size();
        bu = ud_cnt;
        br = rd_cnt;
        unload_start = 1'b1;
        m_ready      = (mode == 0) ? 1'b1 : (mode == 1) ? pat[3] : 1'($urandom_range(0, 1));
        tick();
        unload_start = 1'b0;
        while (ud_cnt == bu && t < 300) begin
            if (cut && (bda.size() - bb) == 5) break;
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[3 - ((t + 1) % 4)] : 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        m_ready = 1'b1;
        if (cut) begin
            rst_n = 1'b0;
            #1;
            check("midreset_idle", {m_valid_a, busy_a, m_last_a, enb_a}, 4'b0000);
            tick();
            check("midreset_held", {m_valid_a, busy_a, m_valid_b, busy_b}, 4'b0000);
            rst_n = 1'b1;
            tick();
        end
        lim = cut ? 5 : N;
        check("beat_count", 64'(bda.size() - bb), 64'(lim));
        for (int i = 0; i < lim; i++) begin
            check("beat_a", {bda[bb+i], bla[bb+i]}, {ref_a[i], 32'(i == N - 1)});
            check("beat_b", {bdb[bb+i], blb[bb+i]}, {ref_b[i], 32'(i == N - 1)});
        end
        if (!cut) begin
            check("unload_done_once", 64'(ud_cnt - bu), 64'd1);
            check("unload_done_timing", 64'(ud_cyc), 64'(bca[bb+N-1] + 1));
            check("read_count", 64'(rd_cnt - br), 64'(N));
            check("idle_after_unload", {busy_a, busy_b}, 2'b00);
        end
        if (mode == 0 && !cut) begin
            check("first_beat_latency", 64'(bca[bb] - 32'(us_cyc)), 64'd2);
            for (int i = 1; i < N; i++)
                check("beat_back_to_back", 64'(bca[bb+i] - bca[bb+i-1]), 64'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; unload_start = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1; preload = 1'b0;
        tick();
        tick();
        check("reset_ctrl", {busy_a, s_ready_a, m_valid_a, m_last_a, ena_a, wea_a, enb_a, web_a,
                             load_done_a, unload_done_a}, 10'd0);
        check("reset_addr", {addra_a, addrb_a, addra_b, addrb_b}, '0);
        check("reset_data", {dina_a, m_data_a}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Fixed ramp 0x10..0x17 streamed with no gaps.
        for (int i = 0; i < N; i++) d[i] = DW'(32'h10 + i);
        do_load(0, 1'b0);

        // Overwrite the RAM with mem[i]=i, then drain at full rate.
        preload = 1'b1;
        tick();
        preload = 1'b0;
        for (int i = 0; i < N; i++) begin ref_a[i] = DW'(i); ref_b[i] = DW'(i); end
        do_unload(0, 1'b0);

        // Gappy load with a stray unload_start; stay in HOLD, ignore a stray load_start.
        for (int i = 0; i < N; i++) d[i] = $urandom;
        do_load(1, 1'b1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        repeat (4) tick();
        check("hold_waits", {busy_a, s_ready_a, m_valid_a, enb_a}, 4'b1000);
        do_unload(1, 1'b0);

        // Random input gaps and random backpressure.
        for (int i = 0; i < N; i++) d[i] = $urandom;
        do_load(2, 1'b0);
        do_unload(2, 1'b0);

        // Reset after five output beats, then a clean frame from wcnt=0.
        for (int i = 0; i < N; i++) d[i] = $urandom;
        do_load(0, 1'b0);
        do_unload(0, 1'b1);
        for (int i = 0; i < N; i++) d[i] = $urandom;
        do_load(2, 1'b0);
        do_unload(0, 1'b0);

        check("output_stable_on_stall", 64'(stab_err), 64'd0);
        check("no_read_overcommit", 64'(ovf_err), 64'd0);
        check("port_a_write_only", 64'(porta_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
